dlfloat16_issue_ctrl: RTL and testbench

//  Issue/sequencing stage directly downstream of the DLFloat16 instruction decoder.
//  - Accepts one decoded op per transaction: ena, rm, op, sel1, sel2, operands and destination.
//  - Resolves the rounding mode, starts the selected execution unit and waits for completion.
//  - Buffers the result for writeback; accumulates sticky exception flags.

---
 rtl/dlfloat16_pkg.sv | 50 +++++
 rtl/dlfloat16_watchdog.sv | 39 +++
 rtl/dlfloat16_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_dlfloat16_issue_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat16_pkg.sv
// Shared definitions for the DLFloat16 issue controller.
//   - ENA_* unit-enable codes produced by the instruction decoder
//   - rounding-mode codes, including the dynamic (frm CSR) selector
//   - issue FSM state type, canonical NaN and exception flag bit positions
//   - small decode helpers used by the controller
package dlfloat16_pkg;

    // Unit-enable codes; 4'b1010 and above are not decoded to any unit.
    localparam logic [3:0] ENA_NONE  = 4'b0000;
    localparam logic [3:0] ENA_ADD   = 4'b0001;
    localparam logic [3:0] ENA_MUL   = 4'b0010;
    localparam logic [3:0] ENA_FMA   = 4'b0011;
    localparam logic [3:0] ENA_DIV   = 4'b0100;
    localparam logic [3:0] ENA_SGNJ  = 4'b0101;
    localparam logic [3:0] ENA_CMP   = 4'b0110;
    localparam logic [3:0] ENA_F2I   = 4'b0111;
    localparam logic [3:0] ENA_I2F   = 4'b1000;
    localparam logic [3:0] ENA_SQRT  = 4'b1001;
    localparam logic [3:0] ENA_LAST  = ENA_SQRT;

    localparam logic [2:0] RM_RSV5   = 3'b101;
    localparam logic [2:0] RM_RSV6   = 3'b110;
    localparam logic [2:0] RM_DYN    = 3'b111;

    localparam logic [15:0] NAN_CANON = 16'h7FFF;

    // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector.
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StWait = 2'b10,
        StResp = 2'b11
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] ena, input logic [2:0] rm);
        return (ena != ENA_NONE) && (ena <= ENA_LAST) && (rm != RM_RSV5) && (rm != RM_RSV6);
    endfunction

    // Sign-inject and compare are purely combinational: their result is valid during EXEC.
    function automatic logic is_comb_unit(input logic [3:0] ena);
        return (ena == ENA_SGNJ) || (ena == ENA_CMP);
    endfunction

endpackage

// File: rtl/dlfloat16_watchdog.sv
// WAIT-state watchdog for the DLFloat16 issue controller (used only when DLF_WDOG_EN is defined).
//   clk, rst_n  clock / asynchronous active-low reset
//   load_i      clear the counter (asserted on the transition into WAIT)
//   run_i       count one cycle (asserted while in WAIT)
//   expired_o   counter has reached TIMEOUT_CYC-1 during a counting cycle
module dlfloat16_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dlfloat16_issue_ctrl.sv
// DLFloat16 issue/sequencing stage, downstream of the instruction decoder.
// Accepts one decoded op, resolves the rounding mode, starts the selected execution unit,
// waits for completion, buffers the result for writeback and accumulates sticky flags.
// Optional feature: define DLF_WDOG_EN to bound the WAIT state with a TIMEOUT_CYC watchdog.
// Ports:
//   in_*        decoded op (valid/ready handshake), frm dynamic rounding-mode CSR
//   unit_*      execution-unit interface: start pulse, latched controls/operands, done/result/flags,
//               abort pulse on watchdog timeout
//   out_*       writeback (valid/ready handshake): data, destination, this op's flags
//   fflags      sticky flags, fflags_clr clears them
//   illegal     one-cycle pulse when an illegal op is dropped
//   timeout_err sticky watchdog error, cleared only by reset
module dlfloat16_issue_ctrl
    import dlfloat16_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned RD_W        = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_ena,
    input  logic [2:0]      in_rm,
    input  logic            in_op,
    input  logic [1:0]      in_sel1,
    input  logic [2:0]      in_sel2,
    input  logic [15:0]     in_a,
    input  logic [15:0]     in_b,
    input  logic [15:0]     in_c,
    input  logic [RD_W-1:0] in_rd,
    input  logic [2:0]      frm,
    output logic            unit_start,
    output logic [3:0]      unit_sel,
    output logic            unit_op,
    output logic [1:0]      unit_sel1,
    output logic [2:0]      unit_sel2,
    output logic [2:0]      unit_rm,
    output logic [15:0]     unit_a,
    output logic [15:0]     unit_b,
    output logic [15:0]     unit_c,
    input  logic            unit_done,
    input  logic [15:0]     unit_result,
    input  logic [4:0]      unit_flags,
    output logic            unit_abort,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data,
    output logic [RD_W-1:0] out_rd,
    output logic [4:0]      out_flags,
    output logic [4:0]      fflags,
    input  logic            fflags_clr,
    output logic            illegal,
    output logic            timeout_err
);

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      sel_q, sel_d;
    logic            op_q, op_d;
    logic [1:0]      sel1_q, sel1_d;
    logic [2:0]      sel2_q, sel2_d;
    logic [2:0]      rm_q, rm_d;
    logic [15:0]     a_q, a_d, b_q, b_d, c_q, c_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [15:0]     data_q, data_d;
    logic [4:0]      flags_q, flags_d;
    logic [4:0]      fflags_q, fflags_d;

    logic            wdog_expired;
    logic            abort;
    logic            cap;
    logic [15:0]     cap_data;
    logic [4:0]      cap_flags;

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        sel_d     = sel_q;
        op_d      = op_q;
        sel1_d    = sel1_q;
        sel2_d    = sel2_q;
        rm_d      = rm_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        rd_d      = rd_q;
        data_d    = data_q;
        flags_d   = flags_q;
        cap       = 1'b0;
        cap_data  = unit_result;
        cap_flags = unit_flags;
        abort     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    sel_d  = in_ena;
                    op_d   = in_op;
                    sel1_d = in_sel1;
                    sel2_d = in_sel2;
                    // Dynamic mode is frozen to the CSR value seen at accept.
                    rm_d   = (in_rm == RM_DYN) ? frm : in_rm;
                    a_d    = in_a;
                    b_d    = in_b;
                    c_d    = in_c;
                    rd_d   = in_rd;
                    if (op_is_legal(in_ena, in_rm)) begin
                        state_d = StExec;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StExec: begin
                if (is_comb_unit(sel_q)) begin
                    cap     = 1'b1;
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A completion in the expiry cycle takes priority over the timeout.
                if (unit_done) begin
                    cap     = 1'b1;
                    state_d = StResp;
                end else if (wdog_expired) begin
                    cap       = 1'b1;
                    cap_data  = NAN_CANON;
                    cap_flags = 5'(1) << FLAG_NV;
                    abort     = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (cap) begin
            data_d  = cap_data;
            flags_d = cap_flags;
        end

        // Registered so that in_ready reads 0 while in reset and during the out_ready cycle.
        in_ready_d = (state_d == StIdle);

        // Clear first, then OR in: a flag raised in the clear cycle survives.
        fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (cap ? cap_flags : 5'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            illegal_q  <= 1'b0;
            sel_q      <= '0;
            op_q       <= 1'b0;
            sel1_q     <= '0;
            sel2_q     <= '0;
            rm_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            rd_q       <= '0;
            data_q     <= '0;
            flags_q    <= '0;
            fflags_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            illegal_q  <= illegal_d;
            sel_q      <= sel_d;
            op_q       <= op_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            rm_q       <= rm_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            flags_q    <= flags_d;
            fflags_q   <= fflags_d;
        end
    end

`ifdef DLF_WDOG_EN
    logic timeout_err_q, timeout_err_d;

    dlfloat16_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   ((state_q != StWait) && (state_d == StWait)),
        .run_i    (state_q == StWait),
        .expired_o(wdog_expired)
    );

    assign timeout_err_d = timeout_err_q | abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign unit_abort  = abort;
    assign timeout_err = timeout_err_q;
`else
    logic unused_wdog;

    assign wdog_expired = 1'b0;
    assign unit_abort   = 1'b0;
    assign timeout_err  = 1'b0;
    assign unused_wdog  = ^{abort, 32'(TIMEOUT_CYC)};
`endif

    assign in_ready   = in_ready_q;
    assign illegal    = illegal_q;
    assign unit_start = (state_q == StExec);
    assign unit_sel   = sel_q;
    assign unit_op    = op_q;
    assign unit_sel1  = sel1_q;
    assign unit_sel2  = sel2_q;
    assign unit_rm    = rm_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign unit_c     = c_q;
    assign out_valid  = (state_q == StResp);
    assign out_data   = data_q;
    assign out_rd     = rd_q;
    assign out_flags  = flags_q;
    assign fflags     = fflags_q;

endmodule

// File: tb/tb_dlfloat16_issue_ctrl.sv
// Self-checking bench for dlfloat16_issue_ctrl. Inputs are driven and outputs sampled on the
// falling clock edge; expected writebacks are queued at issue and popped at the out handshake.
// Define DLF_WDOG_EN for both RTL and bench to exercise the watchdog (TIMEOUT_CYC=16 here).
module tb_dlfloat16_issue_ctrl;
    import dlfloat16_pkg::*;

    localparam int unsigned RD_W        = 5;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid, in_ready;
    logic [3:0]      in_ena;
    logic [2:0]      in_rm;
    logic            in_op;
    logic [1:0]      in_sel1;
    logic [2:0]      in_sel2;
    logic [15:0]     in_a, in_b, in_c;
    logic [RD_W-1:0] in_rd;
    logic [2:0]      frm;
    logic            unit_start;
    logic [3:0]      unit_sel;
    logic            unit_op;
    logic [1:0]      unit_sel1;
    logic [2:0]      unit_sel2, unit_rm;
    logic [15:0]     unit_a, unit_b, unit_c;
    logic            unit_done;
    logic [15:0]     unit_result;
    logic [4:0]      unit_flags;
    logic            unit_abort;
    logic            out_valid, out_ready;
    logic [15:0]     out_data;
    logic [RD_W-1:0] out_rd;
    logic [4:0]      out_flags, fflags;
    logic            fflags_clr, illegal, timeout_err;

    typedef struct packed {
        logic [15:0]     data;
        logic [RD_W-1:0] rd;
        logic [4:0]      flags;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] exp_fflags;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    dlfloat16_issue_ctrl #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .RD_W       (RD_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ena     (in_ena),
        .in_rm      (in_rm),
        .in_op      (in_op),
        .in_sel1    (in_sel1),
        .in_sel2    (in_sel2),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .in_rd      (in_rd),
        .frm        (frm),
        .unit_start (unit_start),
        .unit_sel   (unit_sel),
        .unit_op    (unit_op),
        .unit_sel1  (unit_sel1),
        .unit_sel2  (unit_sel2),
        .unit_rm    (unit_rm),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_c     (unit_c),
        .unit_done  (unit_done),
        .unit_result(unit_result),
        .unit_flags (unit_flags),
        .unit_abort (unit_abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_flags  (out_flags),
        .fflags     (fflags),
        .fflags_clr (fflags_clr),
        .illegal    (illegal),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
        check("in_ready_wait", in_ready, 1);
    endtask

    task automatic drive_op(input logic [3:0] ena, input logic [2:0] rm, input logic [2:0] frm_v,
                            input logic [2:0] sel2, input logic [15:0] a,
                            input logic [RD_W-1:0] rd);
        in_valid = 1'b1;
        in_ena   = ena;
        in_rm    = rm;
        frm      = frm_v;
        in_op    = a[0];
        in_sel1  = a[2:1];
        in_sel2  = sel2;
        in_a     = a;
        in_b     = ~a;
        in_c     = a ^ 16'h5a5a;
        in_rd    = rd;
    endtask

    // One complete legal op. done_dly = WAIT cycles before unit_done (ignored for sgnj/cmp),
    // bp = backpressure cycles, clr = pulse fflags_clr in the capture cycle.
    task automatic do_op(input logic [3:0] ena, input logic [2:0] rm, input logic [2:0] frm_v,
                         input logic [2:0] sel2, input logic [15:0] a, input logic [RD_W-1:0] rd,
                         input logic [15:0] res, input logic [4:0] flg,
                         input int done_dly, input int bp, input bit clr);
        bit         comb;
        logic [2:0] exp_rm;
        exp_t       e;
        comb   = (ena == 4'b0101) || (ena == 4'b0110);
        exp_rm = (rm == 3'b111) ? frm_v : rm;
        wait_ready();
        drive_op(ena, rm, frm_v, sel2, a, rd);
        sb.push_back('{data: res, rd: rd, flags: flg});
        @(negedge clk);
        // EXEC cycle
        in_valid = 1'b0;
        frm      = ~frm_v;
        check("start", unit_start, 1);
        check("unit_sel", unit_sel, ena);
        check("unit_rm", unit_rm, exp_rm);
        check("unit_ctl", {unit_op, unit_sel1, unit_sel2}, {a[0], a[2:1], sel2});
        check("unit_opnd", {unit_a, unit_b, unit_c}, {a, ~a, a ^ 16'h5a5a});
        check("busy", in_ready, 0);
        if (comb) begin
            unit_result = res;
            unit_flags  = flg;
            fflags_clr  = clr;
        end
        @(negedge clk);
        unit_result = 16'hdead;
        unit_flags  = 5'b0;
        fflags_clr  = 1'b0;
        check("start_pulse", unit_start, 0);
        if (!comb) begin
            for (int i = 0; i < done_dly; i++) begin
                check("early_valid", out_valid, 0);
                check("no_abort", unit_abort, 0);
                @(negedge clk);
            end
            unit_done   = 1'b1;
            unit_result = res;
            unit_flags  = flg;
            fflags_clr  = clr;
            #1;
            check("done_wins", unit_abort, 0);
            @(negedge clk);
            unit_done   = 1'b0;
            unit_result = 16'hdead;
            unit_flags  = 5'b0;
            fflags_clr  = 1'b0;
        end
        check("valid_lat", out_valid, 1);
        exp_fflags = (clr ? 5'b0 : exp_fflags) | flg;
        check("fflags", fflags, exp_fflags);
        e = sb[0];
        for (int i = 0; i < bp; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, e.data);
            check("bp_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("hs_valid", out_valid, 1);
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_rd", out_rd, e.rd);
        check("out_flags", out_flags, e.flags);
        check("no_accept", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        check("resp_done", out_valid, 0);
        check("timeout_err", timeout_err, 0);
    endtask

    task automatic illegal_op(input logic [3:0] ena, input logic [2:0] rm);
        wait_ready();
        drive_op(ena, rm, 3'b000, 3'b000, 16'h1111, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        check("illegal_pulse", illegal, 1);
        check("illegal_nostart", unit_start, 0);
        check("illegal_ready", in_ready, 1);
        @(negedge clk);
        check("illegal_one", illegal, 0);
        check("illegal_nostart2", unit_start, 0);
    endtask

    initial begin
        in_valid    = 1'b0;
        in_ena      = '0;
        in_rm       = '0;
        in_op       = 1'b0;
        in_sel1     = '0;
        in_sel2     = '0;
        in_a        = '0;
        in_b        = '0;
        in_c        = '0;
        in_rd       = '0;
        frm         = '0;
        unit_done   = 1'b0;
        unit_result = 16'hdead;
        unit_flags  = '0;
        out_ready   = 1'b0;
        fflags_clr  = 1'b0;
        exp_fflags  = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_start", unit_start, 0);
        check("rst_valid", out_valid, 0);
        check("rst_outs", {unit_sel, unit_rm, unit_a, out_data, out_rd},
              {4'b0, 3'b0, 16'b0, 16'b0, {RD_W{1'b0}}});
        check("rst_flags", {fflags, out_flags, illegal, unit_abort, timeout_err}, 0);
        rst_n = 1'b1;

        // add, done 3 cycles after start
        do_op(4'b0001, 3'b000, 3'b000, 3'b000, 16'h3c00, 5'd5, 16'h4100, 5'b00000, 2, 0, 0);
        // compare: unit_done never asserted
        do_op(4'b0110, 3'b000, 3'b000, 3'b011, 16'h1234, 5'd7, 16'h0001, 5'b10000, 0, 0, 0);
        // dynamic rounding mode resolves to frm at accept
        do_op(4'b0010, 3'b111, 3'b010, 3'b000, 16'h2468, 5'd9, 16'h5555, 5'b00100, 3, 0, 0);
        illegal_op(4'b0001, 3'b101);
        illegal_op(4'b0001, 3'b110);
        illegal_op(4'b0000, 3'b000);
        illegal_op(4'b1010, 3'b001);
        // backpressure on a divide finishing in its first WAIT cycle
        do_op(4'b0100, 3'b001, 3'b000, 3'b000, 16'h4000, 5'd31, 16'hbeef, 5'b01000, 0, 10, 0);
        do_op(4'b0101, 3'b100, 3'b000, 3'b000, 16'h0ace, 5'd1, 16'h8ace, 5'b00000, 0, 2, 0);
        do_op(4'b1001, 3'b111, 3'b011, 3'b000, 16'h7000, 5'd2, 16'h5a00, 5'b00010, 5, 0, 0);
        // NX captured while clearing: only NX remains
        do_op(4'b0110, 3'b000, 3'b000, 3'b001, 16'h0042, 5'd4, 16'h0000, 5'b00001, 0, 0, 1);
        do_op(4'b0011, 3'b000, 3'b000, 3'b000, 16'h1357, 5'd6, 16'h2222, 5'b00001, 1, 0, 1);
`ifdef DLF_WDOG_EN
        // done in the last allowed WAIT cycle still completes normally
        do_op(4'b0111, 3'b010, 3'b000, 3'b000, 16'h0f0f, 5'd12, 16'hf0f0, 5'b00000,
              TIMEOUT_CYC - 1, 0, 0);
`else
        // no watchdog: a long WAIT is legal
        do_op(4'b0111, 3'b010, 3'b000, 3'b000, 16'h0f0f, 5'd12, 16'hf0f0, 5'b00000, 40, 0, 0);
`endif

        // reset in the middle of WAIT drops the op
        check("pre_rst_fflags", fflags, exp_fflags);
        wait_ready();
        drive_op(4'b0011, 3'b000, 3'b000, 3'b000, 16'h7777, 5'd17);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_fflags = '0;
        check("arst_ready", in_ready, 0);
        check("arst_start", unit_start, 0);
        check("arst_valid", out_valid, 0);
        check("arst_outs", {unit_sel, unit_a, unit_c, out_rd}, 0);
        check("arst_fflags", fflags, exp_fflags);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'b0001, 3'b011, 3'b000, 3'b000, 16'h3800, 5'd21, 16'h3e00, 5'b00001, 1, 1, 0);

`ifdef DLF_WDOG_EN
        wait_ready();
        drive_op(4'b0100, 3'b000, 3'b000, 3'b000, 16'h1000, 5'd13);
        sb.push_back('{data: 16'h7FFF, rd: 5'd13, flags: 5'b10000});
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 1; i < int'(TIMEOUT_CYC); i++) begin
            check("wd_early", unit_abort, 0);
            @(negedge clk);
        end
        check("wd_abort", unit_abort, 1);
        @(negedge clk);
        exp_fflags = exp_fflags | 5'b10000;
        check("wd_valid", out_valid, 1);
        check("wd_abort_pulse", unit_abort, 0);
        check("wd_err", timeout_err, 1);
        check("wd_fflags", fflags, exp_fflags);
        out_ready = 1'b1;
        begin
            exp_t e;
            e = sb.pop_front();
            check("wd_data", out_data, e.data);
            check("wd_rd", out_rd, e.rd);
            check("wd_flags", out_flags, e.flags);
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("wd_err_sticky", timeout_err, 1);
`endif

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
